reg_file_ctrl: RTL and testbench
================================

# reg_file_ctrl

Frame-level controller that turns the UART RX byte stream into register-file transactions. It parses 2- and 3-byte command frames, drives the register file's write and read strobes, and waits for read data with a timeout. It returns each read byte to the UART TX path under a busy handshake. It sits between the RX data-sync stage and the register file, on the system (reference) clock domain.

## Interface
- `DATA_WIDTH`, default 8: byte and register width.
- `ADDR_WIDTH`, default 4: register-file address width; the register file has 2^ADDR_WIDTH entries.
- `RD_TIMEOUT`, default 4: maximum cycles from `rf_rd_en` to `rf_rd_data_valid`; range 2..15.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `rx_data` in DATA_WIDTH: received byte.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `rf_address` out ADDR_WIDTH: register-file address.
- `rf_wr_data` out DATA_WIDTH: register-file write data.
- `rf_wr_en` out 1: register-file write strobe, one cycle.
- `rf_rd_en` out 1: register-file read strobe, one cycle.
- `rf_rd_data` in DATA_WIDTH: register-file read data.
- `rf_rd_data_valid` in 1: qualifies `rf_rd_data`.
- `tx_data` out DATA_WIDTH: byte to transmit.
- `tx_valid` out 1: one-cycle pulse; `tx_data` is valid in that cycle.
- `tx_busy` in 1: transmitter cannot accept a byte.
- `cmd_error` out 1: one-cycle error pulse.
- `ctrl_busy` out 1: high whenever state ≠ IDLE.

## Operation
- Frames, first byte = opcode:
  - `0xAA` ADDR DATA: write.
  - `0xBB` ADDR: read.
  - Any other opcode in IDLE: `cmd_error` pulse, byte discarded, stay IDLE.
- ADDR byte: bits [ADDR_WIDTH-1:0] are the address. Any nonzero upper bit gives a `cmd_error` pulse, aborts the frame (no register-file access) and returns to IDLE.
- States and transitions:
  - IDLE: on `rx_valid`, `0xAA` → WR_ADDR; `0xBB` → RD_ADDR.
  - WR_ADDR: on `rx_valid` with a legal address → WR_DATA.
  - WR_DATA: on `rx_valid` → WR_EXEC.
  - WR_EXEC: `rf_wr_en` = 1 for one cycle → IDLE.
  - RD_ADDR: on `rx_valid` with a legal address → RD_EXEC.
  - RD_EXEC: `rf_rd_en` = 1 for one cycle → RD_WAIT.
  - RD_WAIT: on `rf_rd_data_valid`, capture `rf_rd_data` → TX_SEND. If RD_TIMEOUT cycles elapse without valid: `cmd_error` pulse → IDLE.
  - TX_SEND: when `tx_busy` = 0, `tx_valid` pulse → IDLE. Otherwise hold indefinitely.
- `rx_valid` in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: byte dropped, `cmd_error` pulse, state unaffected.
- `rf_wr_en` and `rf_rd_en` are never high together, and each is high for at most one cycle per frame.
- `rf_address` and `rf_wr_data` hold their last values outside strobes.
- The timeout counter is 4 bits, cleared on entry to RD_WAIT, and saturates. No arithmetic wrap is visible.
- A duplicate `rf_rd_data_valid` outside RD_WAIT is ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE; every output 0, including `rf_address`, `rf_wr_data` and `tx_data`.
- Write: last byte accepted at edge N → `rf_wr_en` high in cycle N+1, with address and data stable → `ctrl_busy` low at N+2.
- Read: ADDR accepted at edge N → `rf_rd_en` high in N+1. With a 1-cycle register file, valid arrives in N+2 and `tx_valid` fires in N+3 if `tx_busy` = 0.
- `tx_data` is stable from the `tx_valid` cycle until the next read completes.
- Synchronous reset mid-frame, asserted at any edge: partial frame discarded, no strobe issued after that edge, pending TX byte lost.
- Back-to-back frames are accepted. An opcode byte arriving in the cycle after a write or TX completion is processed normally.

## Structure
- Package `reg_file_ctrl_pkg` holds:
  - opcode constants `WR_CMD` = 8'hAA and `RD_CMD` = 8'hBB;
  - the state encoding (8 states, binary, 3 bits);
  - the timeout counter width.
- One natural sub-module, `rd_timeout_cnt`: a clear/enable saturating counter with a `expired` compare output. All other logic stays in one FSM module.

## Test plan
- Reset then `AA 05 3C` → `rf_wr_en` one cycle with `rf_address` = 5 and `rf_wr_data` = 0x3C; no `cmd_error`.
- `BB 05` with the register file returning 0x3C one cycle after `rf_rd_en`, `tx_busy` = 0 → one `tx_valid` with `tx_data` = 0x3C, 3 cycles after the ADDR byte.
- `BB 02` with `tx_busy` held high 20 cycles → `tx_valid` is the single pulse in the first cycle after `tx_busy` falls; bytes arriving meanwhile each give one `cmd_error` pulse.
- `BB 01` with `rf_rd_data_valid` never asserted → `cmd_error` exactly 4 cycles after `rf_rd_en`, no `tx_valid`, back in IDLE.
- Opcode `0x55`, then `AA 15 77` (address out of range) → two `cmd_error` pulses, no `rf_wr_en`. A following `AA 0F 77` writes address 15.
- `AA 03` then reset held low for one edge, then `77` → no write; `0x77` is treated as an unknown opcode and gives a `cmd_error` pulse.

Source files
------------

// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_ctrl shared definitions
// opcodes, FSM state encoding, timeout counter width
package reg_file_ctrl_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  localparam int TO_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_EXEC = 3'd3,
    RD_ADDR = 3'd4,
    RD_EXEC = 3'd5,
    RD_WAIT = 3'd6,
    TX_SEND = 3'd7
  } state_t;

endpackage

// File: rtl/reg_file_ctrl_rd_timeout_cnt.sv
// rd_timeout_cnt: saturating wait counter for register reads
// expired rises once LIMIT wait cycles have been counted
module rd_timeout_cnt
  import reg_file_ctrl_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  // count enabled cycles, hold at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != '1) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expired = (cnt >= TO_W'(LIMIT));

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: UART byte frames to register-file transactions
// write = AA addr data, read = BB addr, read byte returned on TX
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_data_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  cmd_error,
  output logic                  ctrl_busy
);

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic [DATA_WIDTH-1:0] txd_nx;
  logic wr_nx, rd_nx, txv_nx, err_nx;
  logic is_wr, is_rd, addr_ok;
  logic expired;

  assign is_wr   = (rx_data == DATA_WIDTH'(WR_CMD));
  assign is_rd   = (rx_data == DATA_WIDTH'(RD_CMD));
  assign addr_ok = ((rx_data >> ADDR_WIDTH) == '0);

  // valid may arrive up to RD_TIMEOUT-1 cycles after rf_rd_en
  rd_timeout_cnt #(
    .LIMIT(RD_TIMEOUT - 2)
  ) u_to (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == RD_EXEC),
    .en     (state == RD_WAIT),
    .expired(expired)
  );

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rf_address <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cmd_error  <= 1'b0;
      ctrl_busy  <= 1'b0;
    end else begin
      state      <= state_nx;
      rf_address <= addr_nx;
      rf_wr_data <= wdata_nx;
      rf_wr_en   <= wr_nx;
      rf_rd_en   <= rd_nx;
      tx_data    <= txd_nx;
      tx_valid   <= txv_nx;
      cmd_error  <= err_nx;
      ctrl_busy  <= (state_nx != IDLE);
    end
  end

  // next state and next output values
  always_comb begin
    state_nx = state;
    addr_nx  = rf_address;
    wdata_nx = rf_wr_data;
    txd_nx   = tx_data;
    wr_nx    = 1'b0;
    rd_nx    = 1'b0;
    txv_nx   = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (is_wr) begin
            state_nx = WR_ADDR;
          end else if (is_rd) begin
            state_nx = RD_ADDR;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          if (addr_ok) begin
            addr_nx  = rx_data[ADDR_WIDTH-1:0];
            state_nx = WR_DATA;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wdata_nx = rx_data;
          wr_nx    = 1'b1;
          state_nx = WR_EXEC;
        end
      end
      WR_EXEC: begin
        err_nx   = rx_valid;
        state_nx = IDLE;
      end
      RD_ADDR: begin
        if (rx_valid) begin
          if (addr_ok) begin
            addr_nx  = rx_data[ADDR_WIDTH-1:0];
            rd_nx    = 1'b1;
            state_nx = RD_EXEC;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      RD_EXEC: begin
        err_nx   = rx_valid;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        err_nx = rx_valid;
        if (rf_rd_data_valid) begin
          txd_nx   = rf_rd_data;
          txv_nx   = !tx_busy;
          state_nx = TX_SEND;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      TX_SEND: begin
        err_nx = rx_valid;
        if (tx_valid) begin
          state_nx = IDLE;
        end else if (!tx_busy) begin
          txv_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl: vector table, timing sequences, random frames
// register file and TX sink are modelled inside the bench
module tb_reg_file_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_wr_data;
  logic          rf_wr_en;
  logic          rf_rd_en;
  logic [DW-1:0] rf_rd_data = '0;
  logic          rf_rd_data_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_busy = 1'b0;
  logic          cmd_error;
  logic          ctrl_busy;

  always #5 clk = ~clk;

  reg_file_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RD_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rf_address      (rf_address),
    .rf_wr_data      (rf_wr_data),
    .rf_wr_en        (rf_wr_en),
    .rf_rd_en        (rf_rd_en),
    .rf_rd_data      (rf_rd_data),
    .rf_rd_data_valid(rf_rd_data_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_busy         (tx_busy),
    .cmd_error       (cmd_error),
    .ctrl_busy       (ctrl_busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int wr_n = 0, tx_n = 0, err_n = 0;
  logic [7:0] wr_addr_l, wr_data_l, tx_data_l;
  int s_wr, s_tx, s_err;
  int last_byte_cyc;

  logic [7:0] rf_mem [16];
  logic [7:0] ref_mem [16];
  int rf_lat = 1;
  bit rf_dup = 0;
  bit rf_dup_pend = 0;
  int rf_cnt = 0;
  logic [3:0] rf_raddr = '0;

  typedef struct {
    logic [23:0] bytes;
    int          n;
    int          lat;
    int          busy;
    int          dup;
    int          exp_wr;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
    int          exp_tx;
    logic [7:0]  exp_txd;
    int          exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // observer of DUT strobes
  initial forever begin
    @(negedge clk);
    if (rf_wr_en) begin
      wr_n++;
      wr_addr_l = 8'(rf_address);
      wr_data_l = rf_wr_data;
      rf_mem[rf_address] = rf_wr_data;
    end
    if (rf_wr_en || rf_rd_en)
      check("strobe_excl", 32'(rf_wr_en & rf_rd_en), 0);
    if (tx_valid) begin
      tx_n++;
      tx_data_l = tx_data;
    end
    if (cmd_error) err_n++;
  end

  // register file read responder
  initial forever begin
    @(negedge clk);
    rf_rd_data_valid = 1'b0;
    if (rf_cnt > 0) begin
      rf_cnt--;
      if (rf_cnt == 0) begin
        rf_rd_data_valid = 1'b1;
        rf_rd_data = rf_mem[rf_raddr];
        rf_dup_pend = rf_dup;
      end
    end else if (rf_dup_pend) begin
      rf_rd_data_valid = 1'b1;
      rf_rd_data = ~rf_mem[rf_raddr];
      rf_dup_pend = 0;
    end
    if (rf_rd_en && rf_lat > 0) begin
      rf_cnt = rf_lat;
      rf_raddr = rf_address;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    last_byte_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic snap();
    s_wr = wr_n;
    s_tx = tx_n;
    s_err = err_n;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (ctrl_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(ctrl_busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [23:0] bytes,
                           input int n, input int lat,
                           input int busy, input int dup);
    rf_lat = lat;
    rf_dup = (dup != 0);
    tx_busy = (busy > 0);
    snap();
    for (int i = 0; i < n; i++)
      send_byte(bytes[23-8*i -: 8]);
    repeat (busy) @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic check_frame(input string tag,
                             input int e_wr,
                             input logic [7:0] e_a,
                             input logic [7:0] e_d,
                             input int e_tx,
                             input logic [7:0] e_txd,
                             input int e_err);
    check({tag, " wr_cnt"}, 32'(wr_n - s_wr), 32'(e_wr));
    if (e_wr > 0) begin
      check({tag, " wr_addr"}, 32'(wr_addr_l), 32'(e_a));
      check({tag, " wr_data"}, 32'(wr_data_l), 32'(e_d));
    end
    check({tag, " tx_cnt"}, 32'(tx_n - s_tx), 32'(e_tx));
    if (e_tx > 0)
      check({tag, " tx_data"}, 32'(tx_data_l), 32'(e_txd));
    check({tag, " err_cnt"}, 32'(err_n - s_err), 32'(e_err));
  endtask

  initial begin
    int c;
    int kind;
    logic [7:0] a, d, op;
    bit ok;

    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    tbl[0]  = '{24'hAA053C, 3, 1, 0, 0,
                1, 8'h05, 8'h3C, 0, 8'h00, 0};
    tbl[1]  = '{24'hBB0500, 2, 1, 0, 0,
                0, 8'h00, 8'h00, 1, 8'h3C, 0};
    tbl[2]  = '{24'h550000, 1, 1, 0, 0,
                0, 8'h00, 8'h00, 0, 8'h00, 1};
    tbl[3]  = '{24'hAA1577, 3, 1, 0, 0,
                0, 8'h00, 8'h00, 0, 8'h00, 2};
    tbl[4]  = '{24'hAA0F77, 3, 1, 0, 0,
                1, 8'h0F, 8'h77, 0, 8'h00, 0};
    tbl[5]  = '{24'hBB0F00, 2, 3, 0, 0,
                0, 8'h00, 8'h00, 1, 8'h77, 0};
    tbl[6]  = '{24'hBB0100, 2, 0, 0, 0,
                0, 8'h00, 8'h00, 0, 8'h00, 1};
    tbl[7]  = '{24'hBB0300, 2, 4, 0, 0,
                0, 8'h00, 8'h00, 0, 8'h00, 1};
    tbl[8]  = '{24'hBB0F00, 2, 2, 3, 0,
                0, 8'h00, 8'h00, 1, 8'h77, 0};
    tbl[9]  = '{24'hBB1F00, 2, 1, 0, 0,
                0, 8'h00, 8'h00, 0, 8'h00, 1};
    tbl[10] = '{24'hAA00A5, 3, 1, 0, 0,
                1, 8'h00, 8'hA5, 0, 8'h00, 0};
    tbl[11] = '{24'hBB0000, 2, 1, 2, 1,
                0, 8'h00, 8'h00, 1, 8'hA5, 0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst rf_address", 32'(rf_address), 0);
    check("rst rf_wr_data", 32'(rf_wr_data), 0);
    check("rst rf_wr_en", 32'(rf_wr_en), 0);
    check("rst rf_rd_en", 32'(rf_rd_en), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst tx_valid", 32'(tx_valid), 0);
    check("rst cmd_error", 32'(cmd_error), 0);
    check("rst ctrl_busy", 32'(ctrl_busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // write timing
    snap();
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    c = last_byte_cyc;
    check("wr strobe cyc", 32'(cyc - c), 1);
    check("wr strobe", 32'(rf_wr_en), 1);
    check("wr addr", 32'(rf_address), 32'h5);
    check("wr data", 32'(rf_wr_data), 32'h3C);
    check("wr busy", 32'(ctrl_busy), 1);
    @(negedge clk);
    check("wr strobe end", 32'(rf_wr_en), 0);
    check("wr idle", 32'(ctrl_busy), 0);
    check("wr addr hold", 32'(rf_address), 32'h5);
    wait_idle("wr seq");
    check_frame("wr seq", 1, 8'h05, 8'h3C, 0, 8'h00, 0);
    ref_mem[5] = 8'h3C;

    // read timing, 1-cycle register file
    rf_lat = 1;
    rf_dup = 0;
    snap();
    send_byte(8'hBB);
    send_byte(8'h05);
    check("rd strobe", 32'(rf_rd_en), 1);
    @(negedge clk);
    check("rd strobe end", 32'(rf_rd_en), 0);
    @(negedge clk);
    check("rd tx_valid", 32'(tx_valid), 1);
    check("rd tx_lat", 32'(cyc - last_byte_cyc), 3);
    check("rd tx_data", 32'(tx_data), 32'h3C);
    @(negedge clk);
    check("rd tx_valid end", 32'(tx_valid), 0);
    check("rd idle", 32'(ctrl_busy), 0);
    check("rd tx_data hold", 32'(tx_data), 32'h3C);
    wait_idle("rd seq");
    check_frame("rd seq", 0, 8'h00, 8'h00, 1, 8'h3C, 0);

    // read timeout
    rf_lat = 0;
    snap();
    send_byte(8'hBB);
    send_byte(8'h01);
    check("to strobe", 32'(rf_rd_en), 1);
    repeat (3) @(negedge clk);
    check("to early err", 32'(cmd_error), 0);
    check("to busy", 32'(ctrl_busy), 1);
    @(negedge clk);
    check("to err", 32'(cmd_error), 1);
    check("to idle", 32'(ctrl_busy), 0);
    wait_idle("to seq");
    check_frame("to seq", 0, 8'h00, 8'h00, 0, 8'h00, 1);

    // TX held off by tx_busy, stray bytes meanwhile
    run_frame(24'hAA025A, 3, 1, 0, 0);
    wait_idle("busy pre");
    ref_mem[2] = 8'h5A;
    rf_lat = 1;
    tx_busy = 1'b1;
    snap();
    send_byte(8'hBB);
    send_byte(8'h02);
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'hAA;
      rx_valid = (i % 6 == 3);
      @(negedge clk);
      check("busy no tx", 32'(tx_valid), 0);
    end
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy tx", 32'(tx_valid), 1);
    check("busy tx_data", 32'(tx_data), 32'h5A);
    @(negedge clk);
    check("busy tx end", 32'(tx_valid), 0);
    wait_idle("busy seq");
    check_frame("busy seq", 0, 8'h00, 8'h00, 1, 8'h5A, 3);

    // reset mid-frame
    snap();
    send_byte(8'hAA);
    send_byte(8'h03);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid rst busy", 32'(ctrl_busy), 0);
    check("mid rst addr", 32'(rf_address), 0);
    send_byte(8'h77);
    wait_idle("mid rst");
    check_frame("mid rst", 0, 8'h00, 8'h00, 0, 8'h00, 1);

    // reset drops a pending TX byte
    rf_lat = 1;
    tx_busy = 1'b1;
    snap();
    send_byte(8'hBB);
    send_byte(8'h05);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("tx rst data", 32'(tx_data), 0);
    check("tx rst busy", 32'(ctrl_busy), 0);
    check_frame("tx rst", 0, 8'h00, 8'h00, 0, 8'h00, 0);

    // back-to-back frames
    snap();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h11);
    @(negedge clk);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h22);
    check("b2b wr addr", 32'(rf_address), 32'h2);
    check("b2b wr data", 32'(rf_wr_data), 32'h22);
    @(negedge clk);
    send_byte(8'hBB);
    send_byte(8'h01);
    repeat (2) @(negedge clk);
    check("b2b tx1", 32'(tx_valid), 1);
    check("b2b tx1 data", 32'(tx_data), 32'h11);
    @(negedge clk);
    send_byte(8'hBB);
    send_byte(8'h02);
    repeat (2) @(negedge clk);
    check("b2b tx2", 32'(tx_valid), 1);
    check("b2b tx2 data", 32'(tx_data), 32'h22);
    wait_idle("b2b");
    check_frame("b2b", 2, 8'h02, 8'h22, 2, 8'h22, 0);
    ref_mem[1] = 8'h11;
    ref_mem[2] = 8'h22;

    // vector table
    for (int v = 0; v < 12; v++) begin
      run_frame(tbl[v].bytes, tbl[v].n, tbl[v].lat,
                tbl[v].busy, tbl[v].dup);
      wait_idle($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v),
                  tbl[v].exp_wr, tbl[v].exp_addr,
                  tbl[v].exp_data, tbl[v].exp_tx,
                  tbl[v].exp_txd, tbl[v].exp_err);
      if (tbl[v].exp_wr > 0)
        ref_mem[tbl[v].exp_addr[3:0]] = tbl[v].exp_data;
    end

    // random frames against the transaction model
    for (int r = 0; r < 80; r++) begin
      string tag;
      int lat, busy, dup;
      tag = $sformatf("rnd%0d", r);
      kind = $urandom_range(0, 5);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      lat = $urandom_range(0, 5);
      busy = $urandom_range(0, 4);
      dup = $urandom_range(0, 1);
      if (kind <= 1) begin
        run_frame({8'hAA, a, d}, 3, 1, 0, 0);
        wait_idle(tag);
        check_frame(tag, 1, a, d, 0, 8'h00, 0);
        ref_mem[a[3:0]] = d;
      end else if (kind <= 3) begin
        ok = (lat >= 1 && lat <= TO - 1);
        run_frame({8'hBB, a, 8'h00}, 2, lat, busy, dup);
        wait_idle(tag);
        check_frame(tag, 0, 8'h00, 8'h00,
                    ok ? 1 : 0, ref_mem[a[3:0]],
                    ok ? 0 : 1);
      end else if (kind == 4) begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'hAA || op == 8'hBB) op = 8'h00;
        run_frame({op, 16'h0000}, 1, 1, 0, 0);
        wait_idle(tag);
        check_frame(tag, 0, 8'h00, 8'h00, 0, 8'h00, 1);
      end else begin
        op = (d[0]) ? 8'hAA : 8'hBB;
        a = 8'($urandom_range(16, 255));
        run_frame({op, a, 8'h00}, 2, 1, 0, 0);
        wait_idle(tag);
        check_frame(tag, 0, 8'h00, 8'h00, 0, 8'h00, 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
